// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, Plantard twiddle constants and FSM encoding for the q=3329 NTT blocks
package ntt_pkg;

    localparam int unsigned DATA_WIDTH = 12;
    localparam int unsigned Q          = 3329;
    localparam int unsigned W_FWD      = 3095;
    localparam int unsigned W_INV      = 754;
    localparam int unsigned MULT_LAT   = 4;

    // Plantard reduction returns a*b*(-2^-32) mod q, so the stored twiddle carries -2^32 to cancel it.
    localparam logic [63:0] Q_INV_2_32       = 64'd1806234369;
    localparam logic [63:0] R_MOD_Q          = 64'h1_0000_0000 % 64'(Q);
    localparam logic [63:0] W_INV_PLANT      = (64'(W_INV) * (64'(Q) - R_MOD_Q)) % 64'(Q);
    localparam logic [31:0] W_INV_PLANT_QINV = 32'(W_INV_PLANT * Q_INV_2_32);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/const_mm_inv.sv
// rtl/const_mm_inv.sv - four-stage multiply by W_INV mod Q using Plantard reduction
module const_mm_inv
    import ntt_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] x,
    output logic [data_width-1:0] y
);

    localparam logic signed [31:0] Q_S = $signed(32'(Q));

    logic signed [15:0] hi_q;
    logic signed [16:0] t_q;
    logic signed [31:0] m_q;
    logic signed [15:0] r;

    // The reduced value lands in [-q/2, q/2]; negative results are folded back by adding q.
    assign r = 16'(m_q >>> 16);

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q <= '0;
            t_q  <= '0;
            m_q  <= '0;
            y    <= '0;
        end else begin
            hi_q <= 16'((32'(x) * W_INV_PLANT_QINV) >> 16);
            t_q  <= 17'(hi_q) + 17'sd8;
            m_q  <= 32'(t_q) * Q_S;
            y    <= r[15] ? data_width'(r + 16'(Q)) : data_width'(r);
        end
    end

endmodule

// File: rtl/modular_add.sv
// rtl/modular_add.sv - combinational (a + b) mod Q for operands already below Q
module modular_add #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned Q     = 3329
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    localparam int unsigned W1 = WIDTH + 1;

    logic [WIDTH:0] s;

    assign s = {1'b0, a} + {1'b0, b};
    assign y = (s >= W1'(Q)) ? WIDTH'(s - W1'(Q)) : WIDTH'(s);

endmodule

// File: rtl/modular_substraction.sv
// rtl/modular_substraction.sv - combinational (a - b) mod Q for operands already below Q
module modular_substraction #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned Q     = 3329
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    localparam int unsigned W1 = WIDTH + 1;

    assign y = (a >= b) ? (a - b) : WIDTH'(W1'(a) + W1'(Q) - W1'(b));

endmodule

// File: rtl/pe3_gs_inv.sv
// rtl/pe3_gs_inv.sv - pipelined inverse GS butterfly with PAIRS-per-frame controller
module pe3_gs_inv
    import ntt_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH,
    parameter int unsigned PAIRS      = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] a_in,
    input  logic [data_width-1:0] b_in,
    output logic                  out_valid,
    output logic [data_width-1:0] u_out,
    output logic [data_width-1:0] v_out,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned CW    = $clog2(PAIRS + 1);
    localparam int unsigned CHAIN = MULT_LAT + 2;
    localparam int unsigned DW1   = data_width + 1;

    fsm_state_t            state;
    logic [CW-1:0]         acc_cnt;
    logic [CHAIN-1:0]      vld;
    logic                  accept;
    logic [data_width-1:0] a_q, b_q;
    logic [data_width-1:0] sum_c, diff_c;
    logic [data_width-1:0] sum_q, diff_q;
    logic [data_width-1:0] prod;
    logic [data_width-1:0] sum_dly [MULT_LAT];

    function automatic logic [data_width-1:0] half_mod(input logic [data_width-1:0] x);
        return data_width'(({1'b0, x} + (x[0] ? DW1'(Q) : '0)) >> 1);
    endfunction

    assign in_ready = (state == RUN) && (acc_cnt < CW'(PAIRS));
    assign accept   = in_valid && in_ready;

    modular_add #(.WIDTH(data_width), .Q(Q)) u_add (
        .a (a_q),
        .b (b_q),
        .y (sum_c)
    );

    modular_substraction #(.WIDTH(data_width), .Q(Q)) u_sub (
        .a (a_q),
        .b (b_q),
        .y (diff_c)
    );

    const_mm_inv #(.data_width(data_width)) u_mm (
        .clk (clk),
        .rst (rst),
        .x   (diff_q),
        .y   (prod)
    );

    // vld[k] is set k edges after the accept edge; the output register follows vld[CHAIN-1].
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            diff_q    <= '0;
            for (int i = 0; i < int'(MULT_LAT); i++) sum_dly[i] <= '0;
            out_valid <= 1'b0;
            u_out     <= '0;
            v_out     <= '0;
        end else begin
            vld <= {vld[CHAIN-2:0], accept};
            if (accept) begin
                a_q <= a_in;
                b_q <= b_in;
            end
            sum_q      <= sum_c;
            diff_q     <= diff_c;
            sum_dly[0] <= sum_q;
            for (int i = 1; i < int'(MULT_LAT); i++) sum_dly[i] <= sum_dly[i-1];
            out_valid <= vld[CHAIN-1];
            if (vld[CHAIN-1]) begin
                u_out <= half_mod(sum_dly[MULT_LAT-1]);
                v_out <= half_mod(prod);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            acc_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_valid && !in_ready && (state == RUN || state == DRAIN)) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        acc_cnt  <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        if (acc_cnt == CW'(PAIRS - 1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (vld == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe3_gs_inv.sv
// tb/tb_pe3_gs_inv.sv - randomized self-checking bench for pe3_gs_inv against an arithmetic model
module tb_pe3_gs_inv;
    import ntt_pkg::*;

    localparam int unsigned DW   = 12;
    localparam int unsigned NP   = 128;
    localparam int unsigned INV2 = 1665;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] b_in = '0;
    logic          out_valid;
    logic [DW-1:0] u_out;
    logic [DW-1:0] v_out;
    logic          busy;
    logic          done;
    logic          overflow;

    pe3_gs_inv #(.data_width(DW), .PAIRS(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .u_out     (u_out),
        .v_out     (v_out),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned u;
        int unsigned v;
        int          acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          frame_outs = 0;
    int          n_done = 0;
    int          last_ov_cyc = -100;
    int unsigned drv_u = 0;
    int unsigned drv_v = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned ref_u(input int unsigned a, input int unsigned b);
        return ((a + b) % Q) * INV2 % Q;
    endfunction

    function automatic int unsigned ref_v(input int unsigned a, input int unsigned b);
        int unsigned d;
        d = (a + Q - b) % Q;
        return (d * W_INV % Q) * INV2 % Q;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                check("u_out", 32'(u_out), e.u);
                check("v_out", 32'(v_out), e.v);
                // accept observed here at cycle N; accept edge ends it, output 6 edges later
                check("latency", 32'(cyc - e.acc_cyc), 7);
            end
            frame_outs++;
            last_ov_cyc = cyc;
        end
        if (done) begin
            n_done++;
            check("done_after_last_out", 32'(cyc - last_ov_cyc), 1);
            check("outs_in_frame", 32'(frame_outs), NP);
        end
        if (!rst) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back('{u: drv_u, v: drv_v, acc_cyc: cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned a, input int unsigned b,
                        input int unsigned eu, input int unsigned ev);
        bit ok;
        a_in     = DW'(a);
        b_in     = DW'(b);
        drv_u    = eu;
        drv_v    = ev;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("accept_within_bound", 32'(ok), 1);
    endtask

    task automatic send_rand(input bit gaps);
        int unsigned a, b;
        a = $urandom_range(0, Q - 1);
        b = $urandom_range(0, Q - 1);
        send(a, b, ref_u(a, b), ref_v(a, b));
        if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
    endtask

    task automatic pulse_start();
        frame_outs = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            seen = done;
        end
    endtask

    int unsigned dir_tab [5][4] = '{
        '{5,    3,    4,    754},
        '{3,    5,    4,    2575},
        '{3235, 294,  100,  200},
        '{3328, 3328, 3328, 0},
        '{0,    0,    0,    0}
    };

    initial begin
        bit seen;
        int done_before;

        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_u_out", 32'(u_out), 0);
        check("rst_v_out", 32'(v_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b1;
        tick();

        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_in_ready", 32'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        check("idle_no_overflow", 32'(overflow), 0);

        // frame 1: back-to-back, directed vectors first
        pulse_start();
        check("busy_after_start", 32'(busy), 1);
        for (int i = 0; i < 5; i++) send(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2], dir_tab[i][3]);
        for (int i = 5; i < int'(NP); i++) send_rand(1'b0);
        check("in_ready_drop", 32'(in_ready), 0);
        in_valid = 1'b1;
        start    = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        start    = 1'b0;
        check("overflow_set", 32'(overflow), 1);
        check("busy_in_drain", 32'(busy), 1);
        wait_done(seen);
        check("frame1_done", 32'(seen), 1);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_on_done_ignored", 32'(busy), 0);
        check("overflow_sticky", 32'(overflow), 1);

        // frame 2: gaps, then reset mid-frame
        pulse_start();
        check("busy_frame2", 32'(busy), 1);
        check("overflow_cleared", 32'(overflow), 0);
        for (int i = 0; i < 50; i++) send_rand(1'b1);
        done_before = n_done;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        repeat (20) tick();
        check("midrst_no_done", 32'(n_done), 32'(done_before));
        check("midrst_in_ready", 32'(in_ready), 0);

        // frame 3: fresh frame with random gaps
        pulse_start();
        check("busy_frame3", 32'(busy), 1);
        for (int i = 0; i < int'(NP); i++) send_rand(1'b1);
        wait_done(seen);
        check("frame3_done", 32'(seen), 1);
        tick();
        check("idle_after_done", 32'(busy), 0);
        check("queue_drained", 32'(exp_q.size()), 0);
        check("frame3_no_overflow", 32'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
